// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin arbiter time-sharing one unsigned comparator among NREQ requesters
module comparator_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_eq,
    output logic                  rsp_gt,
    output logic                  rsp_lt,
    input  logic                  rsp_ready
);
    typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;
    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, win, cand;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             valid_q, valid_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic             found, cmp_eq, cmp_gt, cmp_lt;

    // round-robin search starting at the pointer, first valid requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign cmp_eq = a_q == b_q;
    assign cmp_gt = a_q > b_q;
    assign cmp_lt = a_q < b_q;

    assign req_ready = (rst_n && state_q == IDLE && found) ? NREQ'(1) << win : '0;
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_eq    = eq_q;
    assign rsp_gt    = gt_q;
    assign rsp_lt    = lt_q;

    // next-state: grant and capture in IDLE, register the compare, hold until consumed
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = COMPARE;
                ptr_d   = IW'((int'(win) + 1) % NREQ);
                id_d    = win;
                a_d     = WIDTH'(req_a >> (int'(win) * WIDTH));
                b_d     = WIDTH'(req_b >> (int'(win) * WIDTH));
            end
            COMPARE: begin
                state_d = RESPOND;
                valid_d = 1'b1;
                eq_d    = cmp_eq;
                gt_d    = cmp_gt;
                lt_d    = cmp_lt;
            end
            RESPOND: if (rsp_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end
endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The module SHALL have parameter NREQ, default 4, giving the number of requesters; the legal range is 2..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester compare request.
REQ-006 req_a  input  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  NREQ*WIDTH  operand b; same packing as req_a.
REQ-008 req_ready  output  NREQ  one-hot grant; requester i's operands are accepted on the cycle when req_valid[i] and req_ready[i] are both 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-011 rsp_eq, rsp_gt, rsp_lt  output  1 each  unsigned comparison of a against b.
REQ-012 rsp_ready  input  1  consumer accepts the result when rsp_valid and rsp_ready are both 1.

Function
REQ-013 The block SHALL contain exactly one combinational WIDTH-bit unsigned comparator, time-shared among all requesters.
REQ-014 The FSM SHALL have three states: IDLE, COMPARE and RESPOND.
REQ-015 IDLE: if any req_valid bit is 1, the block SHALL assert req_ready for exactly one winner, capture that winner's a, b and id into registers, and go to COMPARE; otherwise it stays in IDLE with req_ready = 0.
REQ-016 req_ready SHALL be combinational from state, pointer and req_valid, and SHALL be all-zero in COMPARE and RESPOND.
REQ-017 Arbitration SHALL be round-robin: the search starts at pointer p and proceeds p, p+1, …, wrapping modulo NREQ; the first index with req_valid set wins.
REQ-018 After a grant to index i, p SHALL become (i+1) mod NREQ; p SHALL NOT change when there is no grant.
REQ-019 COMPARE: the block SHALL register the comparator's eq/gt/lt from the captured operands into rsp_eq/gt/lt, set rsp_valid = 1, and go to RESPOND, always in one cycle.
REQ-020 RESPOND: rsp_valid, rsp_id and rsp_* SHALL hold stable until rsp_ready = 1; on that handshake cycle rsp_valid clears and the FSM returns to IDLE.
REQ-021 Fixed latency: the accept edge is N, so rsp_valid SHALL first be 1 in the cycle after edge N+1; the next grant is possible no earlier than the cycle after the handshake.
REQ-022 Exactly one of rsp_eq, rsp_gt, rsp_lt SHALL be 1 whenever rsp_valid = 1.
REQ-023 Operands SHALL be captured at grant; later changes on req_a/req_b SHALL NOT affect the pending result.
REQ-024 A requester that drops req_valid before being granted SHALL NOT be granted.
REQ-025 If several requests are pending while the block is busy, they SHALL wait; none are queued internally beyond the single captured request.
REQ-026 Boundary values SHALL compare correctly: a = b = 0, a = b = 2^WIDTH-1, and a = 0 with b = 2^WIDTH-1.

Reset
REQ-027 While rst_n = 0: state = IDLE, p = 0, rsp_valid = 0, rsp_id = 0, rsp_eq = rsp_gt = rsp_lt = 0, req_ready = 0, captured operands = 0.
REQ-028 Reset asserted in COMPARE or RESPOND SHALL discard the in-flight request with no response.
REQ-029 After rst_n rises, the first grant SHALL be possible on the first rising edge.

Verification
REQ-030 Single request: req_valid = 0001, a0 = 5, b0 = 9, rsp_ready = 1 -> req_ready = 0001 for one cycle; 2 edges later rsp_valid = 1, rsp_id = 0, lt = 1; rsp_valid = 0 the next cycle.
REQ-031 All-requesting round-robin: req_valid = 1111 held, rsp_ready = 1 -> grant order 0,1,2,3,0 with one grant every 3 cycles.
REQ-032 Backpressure: rsp_ready = 0 for 5 cycles with a = 12, b = 12 -> rsp_valid, rsp_id and eq = 1 held stable; no req_ready while held; release -> return to IDLE.
REQ-033 Wrap and skip: p = 3, req_valid = 0101 -> grant index 0, then index 2.
REQ-034 Extremes: (0,15) -> lt; (15,0) -> gt; (15,15) -> eq; (0,0) -> eq; exactly one flag set each time.
REQ-035 Reset mid-operation: assert rst_n = 0 during RESPOND -> all outputs 0 immediately (asynchronously); after release, req_valid = 1000 -> grant index 3 with p starting from 0.
